// File: rtl/sort_pkg.sv
// Shared definitions for the sort array loader and the quick-sort engine.
//   SORT_WORD_SIZE : default element and index width in bits
//   SORT_DEPTH     : default number of register-file entries available to the sorter
//   ST_*           : loader FSM state encoding
//   cnt_width()    : width of a counter that must hold values 0..depth
package sort_pkg;

    localparam int SORT_WORD_SIZE = 16;
    localparam int SORT_DEPTH     = 10;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_LAUNCH = 2'd2;
    localparam logic [1:0] ST_WAIT   = 2'd3;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sort_array_loader_if.sv
// Bundle of every non-clock signal of the sort array loader.
//   producer side : in_data, in_valid, in_last -> loader; in_ready <- loader
//   register file : wr_en, wr_addr, wr_data <- loader
//   sort engine   : sort_start, sort_A, sort_lo, sort_hi <- loader; sort_done -> loader
//   status        : batch_done, count, truncated <- loader
// Modport slave is the loader itself; master is its environment.
interface sort_array_loader_if
    import sort_pkg::*;
#(
    parameter int WORD_SIZE = SORT_WORD_SIZE,
    parameter int DEPTH     = SORT_DEPTH
);
    localparam int CW = cnt_width(DEPTH);

    logic [WORD_SIZE-1:0] in_data;
    logic                 in_valid;
    logic                 in_last;
    logic                 in_ready;

    logic                 wr_en;
    logic [WORD_SIZE-1:0] wr_addr;
    logic [WORD_SIZE-1:0] wr_data;

    logic                 sort_start;
    logic [WORD_SIZE-1:0] sort_A;
    logic [WORD_SIZE-1:0] sort_lo;
    logic [WORD_SIZE-1:0] sort_hi;
    logic                 sort_done;

    logic                 batch_done;
    logic [CW-1:0]        count;
    logic                 truncated;

    modport master (
        output in_data, in_valid, in_last, sort_done,
        input  in_ready, wr_en, wr_addr, wr_data,
               sort_start, sort_A, sort_lo, sort_hi,
               batch_done, count, truncated
    );

    modport slave (
        input  in_data, in_valid, in_last, sort_done,
        output in_ready, wr_en, wr_addr, wr_data,
               sort_start, sort_A, sort_lo, sort_hi,
               batch_done, count, truncated
    );

endinterface

// File: rtl/sort_array_loader.sv
// Streams a batch of words into the sorter's register file, launches the
// quick-sort engine over the loaded range and reports when the batch is sorted.
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : sort_array_loader_if.slave (producer handshake, register-file
//           write port, engine launch/done, batch status)
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no batch in progress, waiting for the first word
// LOAD   | collecting words, one per cycle, until in_last or full
// LAUNCH | single cycle: start the engine (or finish a 1-word batch)
// WAIT   | engine owns the register file until sort_done
module sort_array_loader
    import sort_pkg::*;
#(
    parameter int WORD_SIZE = SORT_WORD_SIZE,
    parameter int DEPTH     = SORT_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    sort_array_loader_if.slave bus
);

    localparam int CW = cnt_width(DEPTH);

    logic [1:0]    r_state;
    logic [1:0]    w_state_next;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_next;
    logic          r_truncated;
    logic          w_truncated_next;
    logic          r_done_q;
    logic          w_done_next;

    logic          w_ready;
    logic          w_accept;
    logic          w_last_slot;
    logic          w_single;
    logic          w_engine_owns;

    // Strobes are gated by rst_n so that a producer still asserting in_valid
    // during reset cannot write the register file.
    assign w_ready       = rst_n && (r_state == ST_IDLE || r_state == ST_LOAD)
                           && (r_count < CW'(DEPTH));
    assign w_accept      = bus.in_valid && w_ready;
    assign w_last_slot   = (r_count == CW'(DEPTH - 1));
    assign w_single      = (r_state == ST_LAUNCH) && (r_count == CW'(1));
    assign w_engine_owns = (r_state == ST_LAUNCH) || (r_state == ST_WAIT);

    assign bus.in_ready   = w_ready;
    assign bus.wr_en      = w_accept;
    assign bus.wr_addr    = WORD_SIZE'(r_count);
    assign bus.wr_data    = bus.in_data;

    assign bus.sort_start = (r_state == ST_LAUNCH) && (r_count > CW'(1));
    assign bus.sort_A     = '0;
    assign bus.sort_lo    = '0;
    // count is frozen from LAUNCH through WAIT, so hi stays stable for the engine.
    assign bus.sort_hi    = w_engine_owns ? (WORD_SIZE'(r_count) - WORD_SIZE'(1)) : '0;

    // A one-word batch needs no sort and completes in LAUNCH itself; a sorted
    // batch completes the cycle after sort_done, once the FSM is back in IDLE.
    assign bus.batch_done = w_single || r_done_q;
    assign bus.count      = r_count;
    assign bus.truncated  = r_truncated;

    always_comb begin
        w_state_next     = r_state;
        w_count_next     = r_count;
        w_truncated_next = r_truncated;
        w_done_next      = 1'b0;
        case (r_state)
            ST_IDLE, ST_LOAD: begin
                if (w_accept) begin
                    w_count_next = r_count + CW'(1);
                    if (r_state == ST_IDLE) begin
                        w_truncated_next = 1'b0;
                    end
                    if (bus.in_last) begin
                        w_state_next = ST_LAUNCH;
                    end else if (w_last_slot) begin
                        w_truncated_next = 1'b1;
                        w_state_next     = ST_LAUNCH;
                    end else begin
                        w_state_next = ST_LOAD;
                    end
                end
            end
            ST_LAUNCH: begin
                if (w_single) begin
                    w_count_next = '0;
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.sort_done) begin
                    w_count_next = '0;
                    w_done_next  = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_count_next = '0;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_truncated <= 1'b0;
            r_done_q    <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_count     <= w_count_next;
            r_truncated <= w_truncated_next;
            r_done_q    <= w_done_next;
        end
    end

endmodule

// File: tb/tb_sort_array_loader.sv
module tb_sort_array_loader;
    import sort_pkg::*;

    localparam int WS = SORT_WORD_SIZE;
    localparam int DP = SORT_DEPTH;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sort_array_loader_if #(.WORD_SIZE(WS), .DEPTH(DP)) bus ();

    sort_array_loader #(.WORD_SIZE(WS), .DEPTH(DP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;
    int n_wr  = 0;
    int n_ss  = 0;
    int n_bd  = 0;
    int b_wr, b_ss, b_bd;

    logic [WS-1:0] mem [0:DP-1];

    // Register-file model plus strobe counters, sampled at the active edge.
    always @(posedge clk) begin
        if (bus.wr_en) begin
            n_wr++;
            if (int'(bus.wr_addr) < DP) mem[int'(bus.wr_addr)] = bus.wr_data;
        end
        if (bus.sort_start) n_ss++;
        if (bus.batch_done) n_bd++;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic base();
        b_wr = n_wr;
        b_ss = n_ss;
        b_bd = n_bd;
    endtask

    task automatic send(input logic [WS-1:0] d, input bit last, input int addr);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        #1;
        chk("wr_en",   32'(bus.wr_en),   1);
        chk("wr_addr", 32'(bus.wr_addr), 32'(addr));
        chk("wr_data", 32'(bus.wr_data), 32'(d));
        step();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Engine model: sorts mem[lo..hi] and pulses sort_done; returns in the
    // cycle where batch_done is expected high.
    task automatic engine_finish(input int lo, input int hi);
        logic [WS-1:0] t;
        for (int i = lo; i < hi; i++)
            for (int j = lo; j < hi - (i - lo); j++)
                if (mem[j] > mem[j+1]) begin
                    t = mem[j]; mem[j] = mem[j+1]; mem[j+1] = t;
                end
        bus.sort_done = 1'b1;
        #1;
        chk("bd_before_edge", 32'(bus.batch_done), 0);
        step();
        bus.sort_done = 1'b0;
        #1;
        chk("bd_after_done", 32'(bus.batch_done), 1);
        chk("cnt_after_done", 32'(bus.count), 0);
    endtask

    int v36 [10] = '{55, 8, 34, 6, 5, 22, 33, 2, 1, 13};
    int e36 [10] = '{1, 2, 5, 6, 8, 13, 22, 33, 34, 55};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'd99;
        bus.in_last   = 1'b0;
        bus.sort_done = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_count",  32'(bus.count),      0);
        chk("rst_trunc",  32'(bus.truncated),  0);
        chk("rst_wr_en",  32'(bus.wr_en),      0);
        chk("rst_start",  32'(bus.sort_start), 0);
        chk("rst_bd",     32'(bus.batch_done), 0);
        chk("rst_hi",     32'(bus.sort_hi),    0);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        step();
        chk("ready_after_rst", 32'(bus.in_ready), 1);

        // Ten-word batch ending on in_last, sorted by the engine model.
        base();
        for (int i = 0; i < 10; i++) send(WS'(v36[i]), i == 9, i);
        #1;
        chk("b1_start", 32'(bus.sort_start), 1);
        chk("b1_A",     32'(bus.sort_A),     0);
        chk("b1_lo",    32'(bus.sort_lo),    0);
        chk("b1_hi",    32'(bus.sort_hi),    9);
        chk("b1_ready", 32'(bus.in_ready),   0);
        step();
        chk("b1_start_wait", 32'(bus.sort_start), 0);
        chk("b1_hi_wait",    32'(bus.sort_hi),    9);
        step();
        step();
        engine_finish(0, 9);
        chk("b1_ready_idle", 32'(bus.in_ready), 1);
        step();
        for (int i = 0; i < 10; i++) chk("b1_mem", 32'(mem[i]), 32'(e36[i]));
        chk("b1_writes", 32'(n_wr - b_wr), 10);
        chk("b1_starts", 32'(n_ss - b_ss), 1);
        chk("b1_bds",    32'(n_bd - b_bd), 1);

        // Single word: no sort, batch_done in LAUNCH.
        base();
        send(16'd7, 1'b1, 0);
        #1;
        chk("b2_start", 32'(bus.sort_start), 0);
        chk("b2_bd",    32'(bus.batch_done), 1);
        chk("b2_count", 32'(bus.count),      1);
        step();
        chk("b2_bd_off", 32'(bus.batch_done), 0);
        chk("b2_count0", 32'(bus.count),      0);
        chk("b2_ready",  32'(bus.in_ready),   1);
        chk("b2_writes", 32'(n_wr - b_wr), 1);
        chk("b2_starts", 32'(n_ss - b_ss), 0);
        chk("b2_bds",    32'(n_bd - b_bd), 1);

        // Twelve words, no in_last: truncation, words 11 and 12 stall.
        base();
        for (int i = 0; i < 10; i++) send(WS'(100 + i), 1'b0, i);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'd200;
        #1;
        chk("b3_trunc", 32'(bus.truncated),  1);
        chk("b3_ready", 32'(bus.in_ready),   0);
        chk("b3_wr_en", 32'(bus.wr_en),      0);
        chk("b3_hi",    32'(bus.sort_hi),    9);
        chk("b3_start", 32'(bus.sort_start), 1);
        step();
        chk("b3_wr_wait",    32'(bus.wr_en),    0);
        chk("b3_ready_wait", 32'(bus.in_ready), 0);
        step();
        step();
        engine_finish(0, 9);
        chk("b3_ready_idle", 32'(bus.in_ready),  1);
        chk("b3_w11_en",     32'(bus.wr_en),     1);
        chk("b3_w11_addr",   32'(bus.wr_addr),   0);
        chk("b3_trunc_hold", 32'(bus.truncated), 1);
        step();
        chk("b3_trunc_clr", 32'(bus.truncated), 0);
        send(16'd201, 1'b1, 1);
        #1;
        chk("b3_hi2", 32'(bus.sort_hi), 1);
        step();
        engine_finish(0, 1);
        step();
        chk("b3_mem0",   32'(mem[0]), 200);
        chk("b3_mem1",   32'(mem[1]), 201);
        chk("b3_writes", 32'(n_wr - b_wr), 12);

        // in_valid every other cycle over four words.
        base();
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = WS'(40 + i);
            bus.in_last  = (i == 3);
            #1;
            chk("b4_wr_en", 32'(bus.wr_en),   1);
            chk("b4_addr",  32'(bus.wr_addr), 32'(i));
            step();
            bus.in_valid = 1'b0;
            bus.in_last  = 1'b0;
            if (i < 3) begin
                #1;
                chk("b4_gap", 32'(bus.wr_en), 0);
                step();
            end
        end
        #1;
        chk("b4_hi",    32'(bus.sort_hi),    3);
        chk("b4_start", 32'(bus.sort_start), 1);
        step();
        engine_finish(0, 3);
        step();
        chk("b4_writes", 32'(n_wr - b_wr), 4);

        // Reset during WAIT abandons the batch.
        send(16'd9, 1'b0, 0);
        send(16'd3, 1'b0, 1);
        send(16'd4, 1'b1, 2);
        step();
        base();
        #1;
        rst_n = 1'b0;
        #1;
        chk("r_count", 32'(bus.count),      0);
        chk("r_trunc", 32'(bus.truncated),  0);
        chk("r_A",     32'(bus.sort_A),     0);
        chk("r_lo",    32'(bus.sort_lo),    0);
        chk("r_hi",    32'(bus.sort_hi),    0);
        chk("r_start", 32'(bus.sort_start), 0);
        chk("r_bd",    32'(bus.batch_done), 0);
        chk("r_wr_en", 32'(bus.wr_en),      0);
        step();
        rst_n = 1'b1;
        bus.sort_done = 1'b1;
        step();
        bus.sort_done = 1'b0;
        #1;
        chk("r_bd_late", 32'(bus.batch_done), 0);
        chk("r_ready",   32'(bus.in_ready),   1);
        chk("r_bds",     32'(n_bd - b_bd),    0);
        send(16'd77, 1'b1, 0);
        step();

        // sort_done in IDLE is ignored.
        base();
        bus.sort_done = 1'b1;
        #1;
        chk("i_bd", 32'(bus.batch_done), 0);
        step();
        bus.sort_done = 1'b0;
        #1;
        chk("i_bd2",   32'(bus.batch_done), 0);
        chk("i_count", 32'(bus.count),      0);
        chk("i_ready", 32'(bus.in_ready),   1);
        step();
        chk("i_bds", 32'(n_bd - b_bd), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/sort_array_loader.md
SORT_ARRAY_LOADER -- requirements
Module: sort_array_loader

Interface
REQ-001 Parameter WORD_SIZE, default 16, element and index width in bits.
REQ-002 Parameter DEPTH, default 10, register-file entries available to the sorter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_data  input  WORD_SIZE  element offered by the producer.
REQ-006 in_valid  input  1  in_data is valid.
REQ-007 in_last  input  1  qualifies in_data as the final element of a batch.
REQ-008 in_ready  output  1  loader accepts in_data this cycle.
REQ-009 wr_en  output  1  register-file write strobe.
REQ-010 wr_addr  output  WORD_SIZE  register-file write index.
REQ-011 wr_data  output  WORD_SIZE  register-file write data.
REQ-012 sort_start  output  1  one-cycle launch pulse to the quick-sort engine.
REQ-013 sort_A / sort_lo / sort_hi  output  WORD_SIZE each  array base, low index and high index for the engine; held stable from sort_start until sort_done.
REQ-014 sort_done  input  1  engine finished (one-cycle pulse).
REQ-015 batch_done  output  1  one-cycle pulse: batch is sorted in the register file.
REQ-016 count  output  clog2(DEPTH+1)  number of elements loaded in the current batch.
REQ-017 truncated  output  1  sticky: current batch hit DEPTH without in_last.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, LAUNCH and WAIT.
REQ-019 A word is accepted iff in_valid and in_ready are both high on a rising edge.
REQ-020 in_ready SHALL be high in IDLE and LOAD when count < DEPTH, and low otherwise.
REQ-021 Each accepted word SHALL produce wr_en=1, wr_addr=count, wr_data=in_data in the same cycle (combinational from the handshake); count increments on that edge.
REQ-022 IDLE: the first accepted word SHALL clear truncated, write address 0 and go to LOAD, or to LAUNCH if in_last is high.
REQ-023 LOAD: an accepted word with in_last SHALL go to LAUNCH.
REQ-024 LOAD: when count reaches DEPTH without in_last, the FSM SHALL set truncated and go to LAUNCH; further words stall (in_ready low).
REQ-025 LAUNCH with count>=2: sort_start=1 for exactly one cycle, sort_A=0, sort_lo=0, sort_hi=count-1, then WAIT.
REQ-026 LAUNCH with count==1: no sort_start; batch_done pulses in that cycle and the FSM returns to IDLE.
REQ-027 WAIT: on sort_done, batch_done SHALL pulse for one cycle, count clears to 0 and the FSM returns to IDLE; truncated holds until the next batch starts.
REQ-028 A sort_done outside WAIT SHALL be ignored.
REQ-029 wr_en SHALL never be asserted in LAUNCH or WAIT; the register file is owned by the engine from sort_start until sort_done.
REQ-030 Throughput: one word per cycle while loading; LAUNCH lasts exactly one cycle.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, count=0, truncated=0, sort_A/lo/hi=0 and every strobe (wr_en, sort_start, batch_done) low, regardless of state.
REQ-032 Reset asserted mid-LOAD or mid-WAIT SHALL abandon the batch; no batch_done is generated for it.
REQ-033 After rst_n deasserts, in_ready SHALL be high on the first clock edge.

Structure
REQ-034 WORD_SIZE, DEPTH and the state encoding SHALL live in the shared package sort_pkg, shared with quick_sort.
REQ-035 No sub-module: the counter and FSM are a single always block plus a next-state block.

Verification
REQ-036 Stream 55,8,34,6,5,22,33,2,1,13 (last on 13), model the engine -> writes to addresses 0..9; sort_start once with lo=0, hi=9; batch_done one cycle after sort_done; memory reads 1,2,5,6,8,13,22,33,34,55.
REQ-037 Single word 7 with in_last -> write addr 0, no sort_start, batch_done pulse, count returns to 0.
REQ-038 12 words without in_last, DEPTH=10 -> 10 writes, truncated=1, in_ready low, sort_hi=9; words 11 and 12 are accepted only after batch_done.
REQ-039 in_valid toggled every other cycle over 4 words -> exactly 4 writes to addresses 0..3, sort_hi=3.
REQ-040 rst_n pulsed low during WAIT, then sort_done -> no batch_done; outputs all zero; next batch starts at address 0.
REQ-041 sort_done asserted in IDLE -> no state change, no batch_done.
